// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel timeout timer.
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } timer_state_t;

    // 1 ms tick at 100 MHz
    localparam int unsigned DefaultPrescale = 100000;
    localparam int unsigned DefaultCntW     = 32;

endpackage

// File: rtl/timer_channel.sv
// One programmable timeout channel: prescaler, tick counter and IDLE/RUN/DONE FSM.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W    = DefaultCntW,
    parameter int unsigned PRESCALE = DefaultPrescale
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             expire_o
);

    localparam int unsigned   PscW    = $clog2(PRESCALE + 1);
    localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [PscW-1:0]  psc_q, psc_d;
    logic             periodic_q, periodic_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             expire_q, expire_d;
    logic             expire_evt;
    logic             wrap;
    logic [CNT_W-1:0] load_val;

    assign wrap     = (psc_q == PscLast);
    assign load_val = (period_i == '0) ? CNT_W'(1) : period_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= T_IDLE;
            tick_q     <= '0;
            reload_q   <= '0;
            psc_q      <= '0;
            periodic_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            reload_q   <= reload_d;
            psc_q      <= psc_d;
            periodic_q <= periodic_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            expire_q   <= expire_d;
        end
    end

    // Priority: clear, then (re)start, then counting. A tick counter of 1 at a
    // prescaler wrap is the expiry; it never sits at 0 while running.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        reload_d   = reload_q;
        psc_d      = psc_q;
        periodic_d = periodic_q;
        expire_evt = 1'b0;
        if (clear_i) begin
            state_d = T_IDLE;
            tick_d  = '0;
            psc_d   = '0;
        end else if (start_i) begin
            state_d    = T_RUN;
            tick_d     = load_val;
            reload_d   = load_val;
            periodic_d = periodic_i;
            psc_d      = '0;
        end else if (state_q == T_RUN) begin
            if (wrap) begin
                psc_d = '0;
                if (tick_q == CNT_W'(1)) begin
                    expire_evt = 1'b1;
                    if (periodic_q) begin
                        tick_d = reload_q;
                    end else begin
                        state_d = T_DONE;
                        tick_d  = '0;
                    end
                end else begin
                    tick_d = tick_q - CNT_W'(1);
                end
            end else begin
                psc_d = psc_q + PscW'(1);
            end
        end
    end

    always_comb begin
        busy_d   = (state_d == T_RUN);
        done_d   = (state_d == T_DONE);
        expire_d = expire_evt;
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign expire_o = expire_q;

endmodule

// File: rtl/multi_timeout_timer.sv
// NUM_CH independent timeout timers; each channel is a self-contained timer_channel.
module multi_timeout_timer
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = DefaultCntW,
    parameter int unsigned PRESCALE = DefaultPrescale
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic [NUM_CH-1:0]       periodic_i,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       expire_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        timer_channel #(
            .CNT_W    (CNT_W),
            .PRESCALE (PRESCALE)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (start_i[c]),
            .clear_i    (clear_i[c]),
            .periodic_i (periodic_i[c]),
            .period_i   (period_i[c*CNT_W +: CNT_W]),
            .busy_o     (busy_o[c]),
            .done_o     (done_o[c]),
            .expire_o   (expire_o[c])
        );
    end

endmodule

// File: tb/tb_multi_timeout_timer.sv
// Directed bench: two DUT builds (PRESCALE=1 and PRESCALE=4) sharing one clock.
module tb_multi_timeout_timer;

    logic        clk;
    logic        rst;
    logic [3:0]  start_v    [2];
    logic [3:0]  clear_v    [2];
    logic [3:0]  periodic_v [2];
    logic [31:0] period_v   [2];
    logic [3:0]  busy1, done1, exp1;
    logic [3:0]  busy4, done4, exp4;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_timeout_timer #(.NUM_CH(4), .CNT_W(8), .PRESCALE(1)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_v[0]),
        .clear_i    (clear_v[0]),
        .periodic_i (periodic_v[0]),
        .period_i   (period_v[0]),
        .busy_o     (busy1),
        .done_o     (done1),
        .expire_o   (exp1)
    );

    multi_timeout_timer #(.NUM_CH(4), .CNT_W(8), .PRESCALE(4)) u_dut4 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_v[1]),
        .clear_i    (clear_v[1]),
        .periodic_i (periodic_v[1]),
        .period_i   (period_v[1]),
        .busy_o     (busy4),
        .done_o     (done4),
        .expire_o   (exp4)
    );

    typedef struct {
        int         p;
        int         ch;
        bit         per;
        logic [7:0] period;
        int         exp_n;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // {busy, done, expire} of one channel
    function automatic logic [2:0] bde(input int p, input int ch);
        if (p != 0) return {busy4[ch], done4[ch], exp4[ch]};
        return {busy1[ch], done1[ch], exp1[ch]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_ch(input int p, input int ch, input bit per, input logic [7:0] val);
        start_v[p][ch]          = 1'b1;
        periodic_v[p][ch]       = per;
        period_v[p][ch*8 +: 8]  = val;
    endtask

    // Drop requests and scramble mode/period so mid-run changes would show up.
    task automatic release_inputs();
        for (int p = 0; p < 2; p++) begin
            start_v[p]    = '0;
            clear_v[p]    = '0;
            periodic_v[p] = '0;
            period_v[p]   = 32'hFFFF_FFFF;
        end
    endtask

    task automatic quiesce();
        clear_v[0] = '1;
        clear_v[1] = '1;
        step();
        release_inputs();
    endtask

    initial begin
        int         first;
        int         firsts [4];
        logic [2:0] e;

        vecs[0] = '{p: 0, ch: 0, per: 1'b0, period: 8'd10,  exp_n: 10};
        vecs[1] = '{p: 0, ch: 0, per: 1'b0, period: 8'd0,   exp_n: 1};
        vecs[2] = '{p: 1, ch: 1, per: 1'b1, period: 8'd3,   exp_n: 12};
        vecs[3] = '{p: 1, ch: 2, per: 1'b0, period: 8'd1,   exp_n: 4};
        vecs[4] = '{p: 0, ch: 3, per: 1'b0, period: 8'd255, exp_n: 255};
        vecs[5] = '{p: 1, ch: 0, per: 1'b0, period: 8'd0,   exp_n: 4};
        vecs[6] = '{p: 0, ch: 2, per: 1'b1, period: 8'd7,   exp_n: 7};

        rst = 1'b1;
        release_inputs();
        step();
        chk("reset_ps1", 0, {20'h0, busy1, done1, exp1}, 32'h0);
        chk("reset_ps4", 0, {20'h0, busy4, done4, exp4}, 32'h0);
        rst = 1'b0;
        step();

        // Table: first expiry cycle and post-expiry state
        for (int i = 0; i < 7; i++) begin
            quiesce();
            start_ch(vecs[i].p, vecs[i].ch, vecs[i].per, vecs[i].period);
            step();
            release_inputs();
            chk("vec_busy_after_start", i, {29'h0, bde(vecs[i].p, vecs[i].ch)}, 32'h4);
            first = -1;
            for (int n = 1; n <= 400; n++) begin
                step();
                if (bde(vecs[i].p, vecs[i].ch)[0]) begin
                    first = n;
                    break;
                end
            end
            chk("vec_first_expire", i, first, vecs[i].exp_n);
            step();
            chk("vec_after_expire", i, {29'h0, bde(vecs[i].p, vecs[i].ch)},
                vecs[i].per ? 32'h4 : 32'h2);
        end

        // One-shot done is sticky until clear
        quiesce();
        start_ch(0, 0, 1'b0, 8'd10);
        step();
        release_inputs();
        for (int n = 1; n <= 15; n++) step();
        chk("done_sticky", 15, {29'h0, bde(0, 0)}, 32'h2);
        clear_v[0][0] = 1'b1;
        step();
        release_inputs();
        chk("done_cleared", 16, {29'h0, bde(0, 0)}, 32'h0);

        // Periodic, PRESCALE=4, period 3: pulse every 12 cycles for 5 periods
        quiesce();
        start_ch(1, 1, 1'b1, 8'd3);
        step();
        release_inputs();
        for (int n = 1; n <= 60; n++) begin
            step();
            chk("periodic_ps4", n, {29'h0, bde(1, 1)}, {29'h0, 1'b1, 1'b0, (n % 12) == 0});
        end

        // Retrigger at cycle 15 of a 20-cycle one-shot
        quiesce();
        start_ch(0, 2, 1'b0, 8'd20);
        step();
        release_inputs();
        for (int n = 1; n <= 40; n++) begin
            if (n == 15) start_ch(0, 2, 1'b0, 8'd20);
            step();
            release_inputs();
            chk("retrigger_expire", n, {31'h0, bde(0, 2)[0]}, {31'h0, n == 35});
        end

        // Clear mid-count, then start+clear on the same edge
        quiesce();
        start_ch(0, 3, 1'b0, 8'd10);
        step();
        release_inputs();
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) clear_v[0][3] = 1'b1;
            step();
            release_inputs();
            chk("clear_midcount", n, {29'h0, bde(0, 3)}, (n < 5) ? 32'h4 : 32'h0);
        end
        start_ch(0, 3, 1'b0, 8'd3);
        clear_v[0][3] = 1'b1;
        step();
        release_inputs();
        for (int n = 1; n <= 8; n++) begin
            step();
            chk("start_clear_same_edge", n, {29'h0, bde(0, 3)}, 32'h0);
        end

        // Clear on the expiry edge suppresses the pulse
        quiesce();
        start_ch(0, 1, 1'b0, 8'd5);
        step();
        release_inputs();
        for (int n = 1; n <= 10; n++) begin
            if (n == 5) clear_v[0][1] = 1'b1;
            step();
            release_inputs();
            chk("clear_on_expiry", n, {29'h0, bde(0, 1)}, (n < 5) ? 32'h4 : 32'h0);
        end

        // Start coincident with expiry: no pulse, new full period
        quiesce();
        start_ch(0, 0, 1'b0, 8'd5);
        step();
        release_inputs();
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) start_ch(0, 0, 1'b0, 8'd5);
            step();
            release_inputs();
            e = {n < 10, n >= 10, n == 10};
            chk("restart_on_expiry", n, {29'h0, bde(0, 0)}, {29'h0, e});
        end

        // All four channels on one edge, periods 1,2,255,7
        quiesce();
        start_ch(0, 0, 1'b0, 8'd1);
        start_ch(0, 1, 1'b0, 8'd2);
        start_ch(0, 2, 1'b0, 8'd255);
        start_ch(0, 3, 1'b0, 8'd7);
        step();
        release_inputs();
        for (int c = 0; c < 4; c++) firsts[c] = -1;
        for (int n = 1; n <= 300; n++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (exp1[c] && firsts[c] < 0) firsts[c] = n;
            end
        end
        chk("all_ch0_expire", 0, firsts[0], 1);
        chk("all_ch1_expire", 1, firsts[1], 2);
        chk("all_ch2_expire", 2, firsts[2], 255);
        chk("all_ch3_expire", 3, firsts[3], 7);
        chk("all_done", 300, {28'h0, done1}, 32'hF);

        // Asynchronous reset mid-count
        quiesce();
        for (int c = 0; c < 4; c++) begin
            start_ch(0, c, 1'b1, 8'd50);
            start_ch(1, c, 1'b0, 8'd50);
        end
        step();
        release_inputs();
        for (int n = 1; n <= 5; n++) step();
        chk("busy_before_rst", 5, {24'h0, busy1, busy4}, 32'hFF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ps1", 5, {20'h0, busy1, done1, exp1}, 32'h0);
        chk("async_rst_ps4", 5, {20'h0, busy4, done4, exp4}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_after_rst", 0, {24'h0, busy1, busy4}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
